// File: rtl/game_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_seq_ctrl
// Brief    : Key debounce, game state machine, per-frame command word and
//            high-score tracking for the flappy-bird VGA engine (vga_clk).
//            Optional build macro: AUTO_RESTART_EN (leave OVER without a key).
// Revision : 1.0  initial release
// ============================================================================
module game_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int OVER_HOLD_FRAMES = 120,
    parameter int RST_CYCLES       = 16
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [3:0]  key_n,
    input  logic        finish,
    input  logic [19:0] score,
    output logic [3:0]  data_out,
    output logic        game_rst_n,
    output logic [2:0]  state_out,
    output logic        frame_tick,
    output logic [19:0] high_score
);

    localparam int c_db_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_hold_w = $clog2(OVER_HOLD_FRAMES + 1);
    localparam int c_rst_w  = $clog2(RST_CYCLES + 1);

    localparam logic [c_db_w-1:0]   c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(OVER_HOLD_FRAMES);
    localparam logic [c_rst_w-1:0]  c_rst_last = c_rst_w'(RST_CYCLES - 1);

    localparam int c_key_flap  = 0;
    localparam int c_key_left  = 1;
    localparam int c_key_start = 2;
    localparam int c_key_right = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_OVER    = 3'd3,
        ST_RESTART = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    logic [3:0]            r_lvl;
    logic [3:0]            w_lvl_nxt;
    logic                  w_flap_press;
    logic                  w_start_press;

    logic                  w_origin;
    logic                  w_run_nxt;
    logic                  w_stay_play;
    logic                  w_flap_nxt;
    logic                  w_hold_done;
    logic                  w_rst_done;
    logic                  w_enter_over;

    logic                  r_flap_pend;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_rst_w-1:0]    r_rst_cnt;

    // ------------------------------------------------------------------------
    // Key conditioning: samples are inverted on entry so 1 means "pressed".
    // ------------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
        end else begin
            r_sync1 <= ~key_n;
            r_sync2 <= r_sync1;
            r_lvl   <= w_lvl_nxt;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_debounce
        logic [c_db_w-1:0] r_cnt;
        logic              w_accept;

        // r_cnt holds the number of consecutive samples that disagreed with
        // the accepted level; the last one of the run flips the level.
        assign w_accept     = (r_sync2[g] != r_lvl[g]) && (r_cnt == c_db_last);
        assign w_lvl_nxt[g] = w_accept ? r_sync2[g] : r_lvl[g];

        always_ff @(posedge vga_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_cnt <= '0;
            end else if ((r_sync2[g] == r_lvl[g]) || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_flap_press  = w_lvl_nxt[c_key_flap]  & ~r_lvl[c_key_flap];
    assign w_start_press = w_lvl_nxt[c_key_start] & ~r_lvl[c_key_start];

    // ------------------------------------------------------------------------
    // Frame timing and state transitions
    // ------------------------------------------------------------------------
    assign w_origin    = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign w_hold_done = (r_hold_cnt == c_hold_max);
    assign w_rst_done  = (r_rst_cnt == c_rst_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_press) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (finish) begin
                    w_state_nxt = ST_OVER;
                end else if (w_start_press) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_start_press) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_OVER: begin
`ifdef AUTO_RESTART_EN
                if (w_hold_done) begin
                    w_state_nxt = ST_RESTART;
                end
`else
                if (w_hold_done && w_start_press) begin
                    w_state_nxt = ST_RESTART;
                end
`endif
            end
            ST_RESTART: begin
                if (w_rst_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_enter_over = (r_state == ST_PLAY) && (w_state_nxt == ST_OVER);
    assign w_run_nxt    = (w_state_nxt == ST_PLAY);
    assign w_stay_play  = (r_state == ST_PLAY) && w_run_nxt;

    // A flap landing on the origin cycle belongs to the next frame, so the
    // origin cycle replaces the pending flag instead of accumulating into it.
    always_comb begin
        w_flap_nxt = 1'b0;
        if (w_stay_play) begin
            if (w_origin) begin
                w_flap_nxt = w_flap_press;
            end else begin
                w_flap_nxt = r_flap_pend | w_flap_press;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register, counters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_flap_pend <= 1'b0;
            r_hold_cnt  <= '0;
            r_rst_cnt   <= '0;
            data_out    <= '0;
            game_rst_n  <= 1'b1;
            frame_tick  <= 1'b0;
            high_score  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flap_pend <= w_flap_nxt;
            frame_tick  <= w_origin;
            game_rst_n  <= (w_state_nxt != ST_RESTART);

            data_out[0] <= w_flap_nxt;
            data_out[1] <= w_lvl_nxt[c_key_left] & ~w_lvl_nxt[c_key_right] & w_run_nxt;
            data_out[2] <= w_run_nxt;
            data_out[3] <= w_lvl_nxt[c_key_right] & ~w_lvl_nxt[c_key_left] & w_run_nxt;

            if (w_enter_over) begin
                r_hold_cnt <= '0;
                if (score > high_score) begin
                    high_score <= score;
                end
            end else if ((r_state == ST_OVER) && frame_tick && !w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if ((r_state == ST_RESTART) && (w_state_nxt == ST_RESTART)) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    assign state_out = r_state;

endmodule
`default_nettype wire
